// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Holds the FSM state enum, the BCD digit type, display limits and the
// segment decode table (active-low {g,f,e,d,c,b,a}).
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam int unsigned MAX_DISPLAY = 9999;

    // Codes 10..15 never come out of the converter for a saturated value,
    // but they are mapped to blank so a corrupted digit cannot light garbage.
    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Ports: clk, reset (async, active-high), start_i loads bin_i, done_o pulses
// one cycle after the last of DATA_W shift cycles, digits_o = {thousands..ones}.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] bin_i,
    output logic              done_o,
    output bcd_t [3:0]        digits_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [15:0]       bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              done_q, done_d;

    // Add-3 correction on every nibble that would exceed 9 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = {bcd_adj[14:0], bin_q[DATA_W-1]};
            bin_d = {bin_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o   = done_q;
    assign digits_o = bcd_q;

endmodule

// File: rtl/seg7_scan_controller.sv
// 4-digit 7-segment controller: accepts a value (valid/ready, only in IDLE),
// converts it to BCD, commits all four digits at once and scans them out.
// Ports: clk, reset (async, active-high), in_valid/in_ready/in_data input,
// an/seg/dp registered display pins (active-low), busy, overflow status.
// Latency handshake->display registers is DATA_W+2 cycles.
// Build option: LEADING_ZERO_BLANK_EN blanks zero digits above the most
// significant non-zero digit (ones digit is never blanked).
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DATA_W      = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              busy,
    output logic              overflow
);

    generate
        if (NUM_DIGITS != 4) begin : g_bad_num_digits
            $error("seg7_scan_controller supports NUM_DIGITS == 4 only");
        end
        if (REFRESH_DIV < 2) begin : g_bad_refresh_div
            $error("seg7_scan_controller needs REFRESH_DIV >= 2");
        end
    endgenerate

    localparam int PRE_W = $clog2(REFRESH_DIV);

    state_e           state_q, state_d;
    logic             ovf_q, ovf_d;
    bcd_t [3:0]       digit_q, digit_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic              start;
    logic              commit;
    logic              ready_c, busy_c;
    logic              conv_done;
    bcd_t [3:0]        conv_digits;
    logic [31:0]       in_ext;
    logic              in_over;
    logic [DATA_W-1:0] sat_val;
    logic              pre_term;
    logic [3:0]        blank;

    assign in_ext  = 32'(in_data);
    assign in_over = in_ext > 32'(MAX_DISPLAY);
    assign sat_val = in_over ? DATA_W'(MAX_DISPLAY) : in_data;
    assign start   = (state_q == IDLE) && in_valid;

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start),
        .bin_i    (sat_val),
        .done_o   (conv_done),
        .digits_o (conv_digits)
    );

    // Control FSM
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        commit  = 1'b0;
        ready_c = 1'b0;
        busy_c  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    ovf_d   = in_over;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                busy_c = 1'b1;
                if (conv_done) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy_c  = 1'b1;
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digits change only in COMMIT, so the display never sees a partial value.
    assign digit_d = commit ? conv_digits : digit_q;

    // Free-running refresh prescaler and scan index.
    always_comb begin
        pre_term = (pre_q == PRE_W'(REFRESH_DIV - 1));
        pre_d    = pre_term ? '0 : pre_q + PRE_W'(1);
        idx_d    = pre_term ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = (digit_d[3] == 4'd0);
        blank[2] = blank[3] && (digit_d[2] == 4'd0);
        blank[1] = blank[2] && (digit_d[1] == 4'd0);
`endif
    end

    // Outputs are built from next-state index and digits so a commit landing
    // on a scan advance shows the new digit in that same update.
    always_comb begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = blank[idx_d] ? SEG_BLANK : seg_decode(digit_d[idx_d]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            digit_q <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            digit_q <= digit_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign in_ready = ready_c;
    assign busy     = busy_c;
    assign overflow = ovf_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = 1'b1;

endmodule
